// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result buffer: register map, CTRL/STATUS bit
// positions and the capture state machine encoding.
package fft_pkg;

    localparam logic [11:0] CtrlAddr   = 12'h000;
    localparam logic [11:0] StatusAddr = 12'h004;
    localparam logic [11:0] CountAddr  = 12'h008;
    localparam logic [11:0] ResultBase = 12'h100;

    localparam int unsigned CtrlArmBit   = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlClrBit   = 2;

    localparam int unsigned StatBusyBit    = 0;
    localparam int unsigned StatDoneBit    = 1;
    localparam int unsigned StatOverrunBit = 2;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } fsm_e;

endpackage

// File: rtl/fft_res_ram.sv
// Simple dual-port result store: one write port for capture, one registered read
// port for the bus. A same-cycle read and write of one slot returns the old word.
module fft_res_ram #(
    parameter int unsigned Depth = 32,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_result_buffer.sv
// Captures one FFT output frame (optionally bit-reversed) into a result RAM and
// exposes control, status and results as a memory-mapped peripheral with an IRQ.
module fft_result_buffer
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = 32,
    parameter int unsigned DATA_W   = 16,
    parameter bit          BITREV   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              out_valid_i,
    input  logic [DATA_W-1:0] dout_r_i,
    input  logic [DATA_W-1:0] dout_i_i,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [11:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              irq_o,
    output logic              busy_o
);

    localparam int unsigned AW = $clog2(N_POINTS);
    localparam int unsigned CW = AW + 1;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = k[AW-1-i];
        end
        return r;
    endfunction

    // Sign-extend (or truncate) one sample half to 16 bits.
    function automatic logic [15:0] sext16(input logic [DATA_W-1:0] v);
        return 16'(signed'(v));
    endfunction

    fsm_e          state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          irq_en_q, irq_en_d;
    logic          rd_slot_q, rd_slot_d;
    logic [31:0]   reg_rdata_q, reg_rdata_d;

    logic          wr, rd;
    logic [9:0]    widx, slot_off;
    logic          ctrl_hit, status_hit, count_hit, slot_hit;
    logic          arm_wr, clr_wr;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata, ram_rdata;

    assign wr   = en_i && (we_i != 4'b0000);
    assign rd   = en_i && (we_i == 4'b0000);
    assign widx = addr_i[11:2];

    assign ctrl_hit   = (widx == CtrlAddr[11:2]);
    assign status_hit = (widx == StatusAddr[11:2]);
    assign count_hit  = (widx == CountAddr[11:2]);
    assign slot_hit   = (widx >= ResultBase[11:2])
                     && (widx < (ResultBase[11:2] + 10'(N_POINTS)));
    assign slot_off   = widx - ResultBase[11:2];

    assign arm_wr = wr && ctrl_hit && data_i[CtrlArmBit];
    assign clr_wr = wr && ctrl_hit && data_i[CtrlClrBit];

    assign ram_waddr = BITREV ? bitrev(count_q[AW-1:0]) : count_q[AW-1:0];
    assign ram_wdata = {sext16(dout_i_i), sext16(dout_r_i)};
    assign ram_re    = rd && slot_hit;

    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:3], slot_off[9:AW]};

    // CLR is applied before ARM; ARM overrides any sample arriving the same cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        ram_we    = 1'b0;

        if (wr && ctrl_hit) begin
            irq_en_d = data_i[CtrlIrqEnBit];
        end
        if (clr_wr) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
            if (state_q == StDone) begin
                state_d = StIdle;
            end
        end

        if (arm_wr) begin
            state_d   = StArmed;
            count_d   = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (out_valid_i) begin
                        overrun_d = 1'b1;
                    end
                end
                StArmed: begin
                    if (out_valid_i) begin
                        ram_we  = 1'b1;
                        count_d = CW'(1);
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    if (out_valid_i) begin
                        ram_we  = 1'b1;
                        count_d = count_q + 1'b1;
                        if (count_q == CW'(N_POINTS - 1)) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Register reads are captured here; slot reads come from the RAM's output register.
    always_comb begin
        rd_slot_d   = rd_slot_q;
        reg_rdata_d = reg_rdata_q;
        if (rd) begin
            rd_slot_d   = slot_hit;
            reg_rdata_d = '0;
            if (ctrl_hit) begin
                reg_rdata_d[CtrlIrqEnBit] = irq_en_q;
            end
            if (status_hit) begin
                reg_rdata_d[StatBusyBit]    = busy_o;
                reg_rdata_d[StatDoneBit]    = done_q;
                reg_rdata_d[StatOverrunBit] = overrun_q;
            end
            if (count_hit) begin
                reg_rdata_d = 32'(count_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            rd_slot_q   <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            irq_en_q    <= irq_en_d;
            rd_slot_q   <= rd_slot_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    fft_res_ram #(
        .Depth (N_POINTS),
        .AddrW (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (slot_off[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign data_o = rd_slot_q ? ram_rdata : reg_rdata_q;
    assign irq_o  = done_q & irq_en_q;
    assign busy_o = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_fft_result_buffer.sv
// Directed bench for fft_result_buffer (N=32, 16-bit samples, bit-reversed storage).
module tb_fft_result_buffer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        out_valid;
    logic [15:0] dr, di;
    logic        en;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        irq_o, busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fft_result_buffer #(
        .N_POINTS (N),
        .DATA_W   (16),
        .BITREV   (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .out_valid_i (out_valid),
        .dout_r_i    (dr),
        .dout_i_i    (di),
        .en_i        (en),
        .we_i        (we),
        .addr_i      (addr),
        .data_i      (wdata),
        .data_o      (data_o),
        .irq_o       (irq_o),
        .busy_o      (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int br5(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) if (k[i]) r |= (1 << (4 - i));
        return r;
    endfunction

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 4'hF; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 4'h0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 4'h0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = data_o;
    endtask

    task automatic push(input logic [15:0] r, input logic [15:0] i);
        @(negedge clk);
        out_valid = 1'b1; dr = r; di = i;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    // Contiguous burst: sample k = (r0 + k, i0 + istep*k).
    task automatic frame(input logic [15:0] r0, input logic [15:0] i0, input int istep,
                         input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            out_valid = 1'b1;
            dr = r0 + 16'(k);
            di = i0 + 16'(istep * k);
        end
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rv, exp;
        logic [15:0] lo, hi;

        reset_n = 1'b0; out_valid = 1'b0; dr = '0; di = '0;
        en = 1'b0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check_eq("rst_data_o", data_o, 32'h0);
        check_eq("rst_irq", {31'h0, irq_o}, 32'h0);
        check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
        bus_read(12'h004, rv); check_eq("rst_status", rv, 32'h0);
        bus_read(12'h008, rv); check_eq("rst_count", rv, 32'h0);

        // Full bit-reversed frame, r=k, i=-k; done lands right after the last valid
        bus_write(12'h000, 32'h3);
        check_eq("arm_busy", {31'h0, busy_o}, 32'h1);
        bus_read(12'h000, rv); check_eq("ctrl_arm_selfclr", rv, 32'h2);
        frame(16'd0, 16'd0, -1, N - 1);
        check_eq("pre_last_busy", {31'h0, busy_o}, 32'h1);
        bus_read(12'h004, rv); check_eq("pre_last_status", rv, 32'h1);
        frame(16'd31, 16'(-31), -1, 1);
        check_eq("last_busy", {31'h0, busy_o}, 32'h0);
        check_eq("last_irq", {31'h0, irq_o}, 32'h1);
        bus_read(12'h004, rv); check_eq("done_status", rv, 32'h2);
        bus_read(12'h008, rv); check_eq("done_count", rv, 32'd32);
        for (int k = 0; k < N; k++) begin
            lo = 16'(k); hi = 16'(-k);
            exp = {hi, lo};
            bus_read(12'h100 + 12'(4 * br5(k)), rv);
            check_eq($sformatf("slot_br_%0d", k), rv, exp);
        end
        bus_read(12'h004, rv);
        repeat (3) @(negedge clk);
        check_eq("read_hold", data_o, 32'h2);
        bus_read(12'h00C, rv); check_eq("unmapped_reg", rv, 32'h0);
        bus_read(12'h180, rv); check_eq("unmapped_slot", rv, 32'h0);

        // IRQ follows done; CLR drops it the next cycle
        bus_write(12'h000, 32'h6);
        check_eq("clr_irq0", {31'h0, irq_o}, 32'h0);
        bus_write(12'h000, 32'h3);
        frame(16'd100, 16'd0, 1, N);
        check_eq("irq_rise", {31'h0, irq_o}, 32'h1);
        bus_write(12'h000, 32'h6);
        check_eq("irq_drop", {31'h0, irq_o}, 32'h0);
        bus_read(12'h004, rv); check_eq("clr_status", rv, 32'h0);

        // Gapped stream: COUNT moves only on valid
        bus_write(12'h000, 32'h1);
        for (int k = 0; k < N; k++) begin
            push(16'(3 * k), 16'(k + 7));
            if (k % 8 == 3) begin
                bus_read(12'h008, rv); check_eq($sformatf("gap_count_%0d", k), rv, 32'(k + 1));
                bus_read(12'h008, rv); check_eq($sformatf("gap_hold_%0d", k), rv, 32'(k + 1));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus_read(12'h008, rv); check_eq("gap_final_count", rv, 32'd32);
        bus_read(12'h004, rv); check_eq("gap_status", rv, 32'h2);

        // Overrun in DONE and IDLE; buffer and COUNT untouched
        push(16'hAAAA, 16'h5555);
        bus_read(12'h004, rv); check_eq("ovr_done_status", rv, 32'h6);
        bus_read(12'h008, rv); check_eq("ovr_done_count", rv, 32'd32);
        bus_read(12'h100, rv); check_eq("ovr_slot0", rv, {16'd7, 16'd0});
        bus_read(12'h17C, rv); check_eq("ovr_slot31", rv, {16'd38, 16'd93});
        bus_write(12'h000, 32'h4);
        bus_read(12'h004, rv); check_eq("clr_to_idle", rv, 32'h0);
        push(16'hBBBB, 16'hCCCC);
        bus_read(12'h004, rv); check_eq("ovr_idle_status", rv, 32'h4);
        bus_read(12'h008, rv); check_eq("ovr_idle_count", rv, 32'd32);
        bus_read(12'h100, rv); check_eq("ovr_idle_slot0", rv, {16'd7, 16'd0});
        bus_write(12'h000, 32'h4);

        // Restart mid-frame discards the partial frame
        bus_write(12'h000, 32'h1);
        frame(16'h0500, 16'h0050, 1, 10);
        bus_read(12'h008, rv); check_eq("partial_count", rv, 32'd10);
        bus_write(12'h000, 32'h1);
        bus_read(12'h008, rv); check_eq("rearm_count", rv, 32'd0);
        frame(16'h0600, 16'h0000, 1, N);
        bus_read(12'h008, rv); check_eq("rearm_final_count", rv, 32'd32);
        for (int k = 0; k < N; k++) begin
            lo = 16'h0600 + 16'(k); hi = 16'(k);
            exp = {hi, lo};
            bus_read(12'h100 + 12'(4 * br5(k)), rv);
            check_eq($sformatf("rearm_slot_%0d", k), rv, exp);
        end

        // Reset mid-capture
        bus_write(12'h000, 32'h3);
        frame(16'h0700, 16'h0000, 1, 10);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check_eq("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        check_eq("mid_rst_irq", {31'h0, irq_o}, 32'h0);
        check_eq("mid_rst_data_o", data_o, 32'h0);
        bus_read(12'h004, rv); check_eq("mid_rst_status", rv, 32'h0);
        bus_read(12'h008, rv); check_eq("mid_rst_count", rv, 32'h0);
        bus_read(12'h000, rv); check_eq("mid_rst_ctrl", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
